// File: rtl/residue_pkg.sv
// residue_pkg: shared widths, FIFO sizing and FSM encoding for residue_pack_collector.
`default_nettype none

package residue_pkg;

  localparam int RES_W      = 30;
  localparam int ADDR_W     = 6;
  localparam int CNT_W      = 3;
  localparam int NUM_QI     = 6;
  localparam int FIFO_DEPTH = 4;

  localparam int PAIR_W  = ADDR_W - 1;
  localparam int WORD_W  = 2 * RES_W;
  localparam int MEM_AW  = CNT_W + PAIR_W;
  localparam int ENTRY_W = MEM_AW + WORD_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Memory word address: modulus index above the coefficient pair index.
  function automatic logic [MEM_AW-1:0] pair_addr(input logic [CNT_W-1:0]  cnt,
                                                  input logic [PAIR_W-1:0] pair);
    return {cnt, pair};
  endfunction

endpackage

`default_nettype wire

// File: rtl/res_pack_fifo.sv
// res_pack_fifo: show-ahead FIFO accepting up to two ordered pushes per cycle; unaccepted pushes flag drop.
`default_nettype none

module res_pack_fifo #(
  parameter int WIDTH = 68,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0,
  input  logic [WIDTH-1:0] din0,
  input  logic             push1,
  input  logic [WIDTH-1:0] din1,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr, wr_ptr1;
  logic [OCC_W-1:0] count, space;
  logic             pop_ok, acc0, acc1;

  // A pop in the same cycle frees a slot for the incoming push.
  always_comb begin
    pop_ok  = pop & ~empty;
    space   = OCC_W'(DEPTH) - count + OCC_W'(pop_ok);
    acc0    = push0 && (space != '0);
    acc1    = push1 && (space > OCC_W'(acc0));
    wr_ptr1 = wr_ptr + PTR_W'(acc0);
  end

  assign full  = (count == OCC_W'(DEPTH));
  assign empty = (count == '0);
  assign drop  = (push0 & ~acc0) | (push1 & ~acc1);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (acc0) mem[wr_ptr]  <= din0;
    if (acc1) mem[wr_ptr1] <= din1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PTR_W'(pop_ok);
      wr_ptr <= wr_ptr + PTR_W'(acc0) + PTR_W'(acc1);
      count  <= count + OCC_W'(acc0) + OCC_W'(acc1) - OCC_W'(pop_ok);
    end
  end

endmodule

`default_nettype wire

// File: rtl/residue_pack_collector.sv
// residue_pack_collector: pairs even/odd residues into 60-bit memory words through a 4-deep FIFO.
// Sticky pair_err/overflow flags are built only when RES_COLLECT_ERRFLAG_EN is defined.
`default_nettype none

module residue_pack_collector
  import residue_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [RES_W-1:0]  res_data,
  input  logic [ADDR_W-1:0] res_addr,
  input  logic              res_write,
  input  logic [CNT_W-1:0]  res_counter,
  input  logic              res_done,
  output logic [WORD_W-1:0] mem_din,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              in_ready,
  output logic              done,
  output logic              pair_err,
  output logic              overflow
);

  state_t              state, state_nxt;
  logic [RES_W-1:0]    lat_data;
  logic [CNT_W-1:0]    lat_cnt;
  logic [PAIR_W-1:0]   lat_pair;
  logic                latch, half_nxt, err_hit, done_nxt;
  logic                push0, push1;
  logic [ENTRY_W-1:0]  entry0, entry1, head;
  logic [ENTRY_W-1:0]  half_entry, new_half, odd_entry, full_entry;
  logic [PAIR_W-1:0]   in_pair;
  logic                cnt_ok, match;
  logic                fifo_full, fifo_empty, fifo_drop;

  assign in_pair    = res_addr[ADDR_W-1:1];
  assign cnt_ok     = (res_counter < CNT_W'(NUM_QI));
  assign match      = (res_counter == lat_cnt) && (in_pair == lat_pair);
  assign half_entry = {pair_addr(lat_cnt, lat_pair), {RES_W{1'b0}}, lat_data};
  assign new_half   = {pair_addr(res_counter, in_pair), {RES_W{1'b0}}, res_data};
  assign odd_entry  = {pair_addr(res_counter, in_pair), res_data, {RES_W{1'b0}}};
  assign full_entry = {pair_addr(lat_cnt, lat_pair), res_data, lat_data};

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    half_nxt  = (state == ST_HALF);
    err_hit   = 1'b0;
    done_nxt  = 1'b0;
    push0     = 1'b0;
    push1     = 1'b0;
    entry0    = '0;
    entry1    = '0;
    if (state == ST_DRAIN) begin
      err_hit = res_write;
      if (fifo_empty) begin
        done_nxt  = 1'b1;
        state_nxt = ST_EMPTY;
      end
    end else begin
      if (res_write && !cnt_ok) begin
        err_hit = 1'b1;
      end else if (res_write && !res_addr[0]) begin
        if (half_nxt) begin
          push0   = 1'b1;
          entry0  = half_entry;
          err_hit = 1'b1;
        end
        latch    = 1'b1;
        half_nxt = 1'b1;
      end else if (res_write) begin
        if (half_nxt && match) begin
          push0  = 1'b1;
          entry0 = full_entry;
        end else if (half_nxt) begin
          push0   = 1'b1;
          entry0  = half_entry;
          push1   = 1'b1;
          entry1  = odd_entry;
          err_hit = 1'b1;
        end else begin
          push0   = 1'b1;
          entry0  = odd_entry;
          err_hit = 1'b1;
        end
        half_nxt = 1'b0;
      end
      // The write of this cycle is already folded in; flush whatever half word remains.
      if (res_done) begin
        state_nxt = ST_DRAIN;
        if (half_nxt) begin
          err_hit = 1'b1;
          if (push0) begin
            push1  = 1'b1;
            entry1 = latch ? new_half : half_entry;
          end else begin
            push0  = 1'b1;
            entry0 = latch ? new_half : half_entry;
          end
        end
      end else begin
        state_nxt = half_nxt ? ST_HALF : ST_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_EMPTY;
      lat_data <= '0;
      lat_cnt  <= '0;
      lat_pair <= '0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
      if (latch) begin
        lat_data <= res_data;
        lat_cnt  <= res_counter;
        lat_pair <= in_pair;
      end
    end
  end

  res_pack_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push0 (push0),
    .din0  (entry0),
    .push1 (push1),
    .din1  (entry1),
    .pop   (mem_we & mem_ready),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop)
  );

  // Head is masked while empty so the memory port idles at zero.
  assign mem_we   = ~fifo_empty;
  assign mem_din  = fifo_empty ? '0 : head[WORD_W-1:0];
  assign mem_addr = fifo_empty ? '0 : head[ENTRY_W-1:WORD_W];
  assign in_ready = ~fifo_full;

`ifdef RES_COLLECT_ERRFLAG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pair_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (err_hit)   pair_err <= 1'b1;
      if (fifo_drop) overflow <= 1'b1;
    end
  end
`else
  logic unused_err;
  assign unused_err = err_hit | fifo_drop;
  assign pair_err   = 1'b0;
  assign overflow   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_residue_pack_collector.sv
// tb_residue_pack_collector: directed and random stimulus against a queue-based reference model.
`default_nettype none

module tb_residue_pack_collector;

`ifdef RES_COLLECT_ERRFLAG_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] res_data = '0;
  logic [5:0]  res_addr = '0;
  logic        res_write = 1'b0;
  logic [2:0]  res_counter = '0;
  logic        res_done = 1'b0;
  logic        mem_ready = 1'b0;
  logic [59:0] mem_din;
  logic [7:0]  mem_addr;
  logic        mem_we, in_ready, done, pair_err, overflow;

  int errors = 0;
  int checks = 0;

  residue_pack_collector dut (
    .clk(clk), .rst(rst), .res_data(res_data), .res_addr(res_addr),
    .res_write(res_write), .res_counter(res_counter), .res_done(res_done),
    .mem_din(mem_din), .mem_addr(mem_addr), .mem_we(mem_we), .mem_ready(mem_ready),
    .in_ready(in_ready), .done(done), .pair_err(pair_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a word queue of {addr, odd, even} plus pairing bookkeeping.
  logic [67:0] q[$];
  bit          m_pend, m_drain, m_done, m_perr, m_ovf;
  logic [2:0]  m_pc;
  logic [4:0]  m_pp;
  logic [29:0] m_pd;

  task automatic model_reset();
    q.delete();
    m_pend = 0; m_drain = 0; m_done = 0; m_perr = 0; m_ovf = 0;
    m_pc = '0; m_pp = '0; m_pd = '0;
  endtask

  task automatic model_step(input logic w, input logic [5:0] a, input logic [29:0] d,
                            input logic [2:0] c, input logic rd, input logic rdy);
    logic [67:0] pl[$];
    bit pop;
    pop = rdy && (q.size() != 0);
    m_done = 0;
    if (m_drain) begin
      if (w) m_perr = 1;
      if (q.size() == 0) begin m_done = 1; m_drain = 0; end
    end else begin
      if (w && c > 3'd5) m_perr = 1;
      else if (w && !a[0]) begin
        if (m_pend) begin pl.push_back({m_pc, m_pp, 30'd0, m_pd}); m_perr = 1; end
        m_pend = 1; m_pc = c; m_pp = a[5:1]; m_pd = d;
      end else if (w) begin
        if (m_pend && m_pc == c && m_pp == a[5:1]) pl.push_back({c, a[5:1], d, m_pd});
        else begin
          if (m_pend) pl.push_back({m_pc, m_pp, 30'd0, m_pd});
          pl.push_back({c, a[5:1], d, 30'd0});
          m_perr = 1;
        end
        m_pend = 0;
      end
      if (rd) begin
        if (m_pend) begin pl.push_back({m_pc, m_pp, 30'd0, m_pd}); m_perr = 1; m_pend = 0; end
        m_drain = 1;
      end
    end
    if (pop) void'(q.pop_front());
    foreach (pl[i]) begin
      if (q.size() < 4) q.push_back(pl[i]);
      else m_ovf = 1;
    end
  endtask

  function automatic logic [72:0] exp_vec();
    logic [67:0] h;
    h = (q.size() != 0) ? q[0] : 68'd0;
    return {q.size() != 0, h, m_done, q.size() != 4, ERR_EN & m_perr, ERR_EN & m_ovf};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, return at the next falling edge.
  task automatic tick(input logic w, input logic [5:0] a, input logic [29:0] d,
                      input logic [2:0] c, input logic rd, input logic rdy);
    res_write = w; res_addr = a; res_data = d; res_counter = c; res_done = rd; mem_ready = rdy;
    @(posedge clk);
    model_step(w, a, d, c, rd, rdy);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    tick(1'b0, 6'd0, 30'd0, 3'd0, 1'b0, rdy);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({mem_we, mem_addr, mem_din, done, pair_err, overflow, in_ready} !== {72'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got we=%b addr=%h din=%h done=%b perr=%b ovf=%b rdy=%b exp zeros and in_ready=1",
               mem_we, mem_addr, mem_din, done, pair_err, overflow, in_ready);
    end
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
    idle(1'b1);
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got we=%b in_ready=%b exp 0/1", mem_we, in_ready);
    end
  endtask

  task automatic test_pair();
    tick(1'b1, 6'd4, 30'h1234567, 3'd2, 1'b0, 1'b1);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL pair_even_no_write: got we=%b exp 0", mem_we); end
    tick(1'b1, 6'd5, 30'h0ABCDEF, 3'd2, 1'b0, 1'b1);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h42 || mem_din !== {30'h0ABCDEF, 30'h1234567}) begin
      errors++;
      $display("FAIL pair_word: got we=%b addr=%h din=%h exp 1 42 %h", mem_we, mem_addr, mem_din,
               {30'h0ABCDEF, 30'h1234567});
    end
    idle(1'b1);
    checks++;
    if (mem_we !== 1'b0) begin errors++; $display("FAIL pair_popped: got we=%b exp 0", mem_we); end
  endtask

  task automatic test_sweep();
    int n_xfer, last_we, done_cyc, cyc;
    logic [72:0] obs;
    n_xfer = 0; last_we = -1; done_cyc = -1; cyc = 0;
    for (int c = 0; c < 6; c++) begin
      for (int a = 0; a < 64; a++) begin
        tick(1'b1, 6'(a), 30'($urandom), 3'(c), (c == 5 && a == 63), 1'b1);
        cyc++;
        obs = {mem_we, mem_addr, mem_din, done, in_ready, pair_err, overflow};
        checks++;
        if (obs !== exp_vec()) begin errors++; $display("FAIL sweep_cycle %0d: got %h exp %h", cyc, obs, exp_vec()); end
        if (mem_we) begin
          checks++;
          if (mem_addr !== 8'(n_xfer)) begin errors++; $display("FAIL sweep_order: got addr %h exp %h", mem_addr, 8'(n_xfer)); end
          n_xfer++; last_we = cyc;
        end
      end
    end
    for (int i = 0; i < 10 && done_cyc < 0; i++) begin
      idle(1'b1);
      cyc++;
      if (mem_we) begin n_xfer++; last_we = cyc; end
      if (done) done_cyc = cyc;
    end
    checks++;
    if (n_xfer != 192) begin errors++; $display("FAIL sweep_count: got %0d exp 192", n_xfer); end
    checks++;
    if (done_cyc != last_we + 2) begin
      errors++;
      $display("FAIL sweep_done_timing: got done at %0d exp %0d", done_cyc, last_we + 2);
    end
    checks++;
    if (pair_err !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sweep_no_errors: got perr=%b ovf=%b exp 0 0", pair_err, overflow);
    end
  endtask

  task automatic test_mismatch();
    logic [29:0] d6, d8, d9;
    d6 = 30'($urandom); d8 = 30'($urandom); d9 = 30'($urandom);
    tick(1'b1, 6'd6, d6, 3'd1, 1'b0, 1'b1);
    checks++;
    if (mem_we !== 1'b0 || pair_err !== 1'b0) begin
      errors++; $display("FAIL mis_first: got we=%b perr=%b exp 0 0", mem_we, pair_err);
    end
    tick(1'b1, 6'd8, d8, 3'd1, 1'b0, 1'b1);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h23 || mem_din !== {30'd0, d6} || pair_err !== ERR_EN) begin
      errors++;
      $display("FAIL mis_padded: got we=%b addr=%h din=%h perr=%b exp 1 23 %h %b",
               mem_we, mem_addr, mem_din, pair_err, {30'd0, d6}, ERR_EN);
    end
    tick(1'b1, 6'd9, d9, 3'd1, 1'b0, 1'b1);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h24 || mem_din !== {d9, d8}) begin
      errors++;
      $display("FAIL mis_held_half: got we=%b addr=%h din=%h exp 1 24 %h", mem_we, mem_addr, mem_din, {d9, d8});
    end
    idle(1'b1);
  endtask

  task automatic test_overflow();
    logic [67:0] expw[4];
    logic [29:0] de, dd;
    int k;
    for (int i = 0; i < 5; i++) begin
      de = 30'($urandom); dd = 30'($urandom);
      if (i < 4) expw[i] = {3'd3, 5'(i), dd, de};
      tick(1'b1, 6'(2 * i), de, 3'd3, 1'b0, 1'b0);
      tick(1'b1, 6'(2 * i + 1), dd, 3'd3, 1'b0, 1'b0);
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ovf_ready_3: got %b exp 1", in_ready); end
      end
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready_4: got %b exp 0", in_ready); end
      end
    end
    checks++;
    if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag: got %b exp %b", overflow, ERR_EN); end
    k = 0;
    for (int i = 0; i < 12; i++) begin
      mem_ready = 1'b1;
      if (mem_we) begin
        checks++;
        if (k > 3 || {mem_addr, mem_din} !== expw[k[1:0]]) begin
          errors++;
          $display("FAIL ovf_drain_word %0d: got %h exp %h", k, {mem_addr, mem_din}, expw[k[1:0]]);
        end
        k++;
      end
      idle(1'b1);
    end
    checks++;
    if (k != 4) begin errors++; $display("FAIL ovf_drain_count: got %0d exp 4", k); end
  endtask

  task automatic test_random();
    logic [72:0] obs;
    logic [4:0]  pair;
    logic        par;
    logic [5:0]  a;
    logic [2:0]  c;
    pair = 5'($urandom); par = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) a = 6'($urandom);
      else a = {pair, par};
      c = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 1));
      tick($urandom_range(0, 3) != 0, a, 30'($urandom), c, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) != 0);
      if (res_write) begin
        par = ~par;
        if (!par) pair = pair + 5'd1;
      end
      obs = {mem_we, mem_addr, mem_din, done, in_ready, pair_err, overflow};
      checks++;
      if (obs !== exp_vec()) begin errors++; $display("FAIL random_cycle %0d: got %h exp %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    int n_we;
    tick(1'b1, 6'd0, 30'($urandom), 3'd0, 1'b0, 1'b0);
    tick(1'b1, 6'd1, 30'($urandom), 3'd0, 1'b0, 1'b0);
    tick(1'b1, 6'd2, 30'($urandom), 3'd0, 1'b0, 1'b0);
    tick(1'b1, 6'd3, 30'($urandom), 3'd0, 1'b0, 1'b0);
    tick(1'b1, 6'd4, 30'($urandom), 3'd0, 1'b0, 1'b0);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_setup: got we=%b exp 1", mem_we); end
    res_write = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({mem_we, mem_addr, mem_din, done, pair_err, overflow, in_ready} !== {72'd0, 1'b1}) begin
      errors++;
      $display("FAIL midrst_outputs: got we=%b addr=%h din=%h done=%b perr=%b ovf=%b rdy=%b exp zeros and in_ready=1",
               mem_we, mem_addr, mem_din, done, pair_err, overflow, in_ready);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (mem_we) n_we++;
    end
    checks++;
    if (n_we != 0) begin errors++; $display("FAIL midrst_no_write: got %0d writes exp 0", n_we); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_pair();
    test_sweep();
    test_mismatch();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/residue_pack_collector.md
RESIDUE_PACK_COLLECTOR -- requirements
Module: residue_pack_collector

Interface
REQ-001 SHALL have clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have rst, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have res_data, input, 30, reduced residue word from the 30-bit qi reduction stage.
REQ-004 SHALL have res_addr, input, 6, residue coefficient address (0..63).
REQ-005 SHALL have res_write, input, 1, residue valid strobe, one residue per asserted cycle.
REQ-006 SHALL have res_counter, input, 3, modulus index qi (0..5 legal).
REQ-007 SHALL have res_done, input, 1, one-cycle pulse: producer finished a burst.
REQ-008 SHALL have mem_din, output, 60, packed word {odd residue, even residue}.
REQ-009 SHALL have mem_addr, output, 8, {res_counter, res_addr[5:1]}.
REQ-010 SHALL have mem_we, output, 1, memory write strobe.
REQ-011 SHALL have mem_ready, input, 1; a word transfers on a cycle with mem_we=1 and mem_ready=1.
REQ-012 SHALL have in_ready, output, 1, deasserted when the FIFO holds 4 words.
REQ-013 SHALL have done, output, 1, one-cycle completion pulse.
REQ-014 SHALL have pair_err and overflow, outputs, 1 each, sticky error flags.

Function
REQ-015 SHALL use a 3-state FSM: EMPTY (no half word pending), HALF (even residue latched), DRAIN (res_done seen, emptying).
REQ-016 EMPTY + res_write with even res_addr SHALL latch residue, counter and address, then go to HALF.
REQ-017 HALF + res_write with odd res_addr, same counter and res_addr[5:1] SHALL push {res_data, latched} to the FIFO, then go to EMPTY.
REQ-018 HALF + even res_write SHALL push {30'd0, latched}, set pair_err, latch the new residue and stay in HALF.
REQ-019 Odd res_write in EMPTY, or an odd one that mismatches in HALF, SHALL push {res_data, 30'd0} at its own address and set pair_err; a mismatch in HALF first pushes {30'd0, latched}.
REQ-020 res_counter>5 SHALL be dropped with pair_err set.
REQ-021 The FIFO SHALL be 4 deep, 68 bits wide (data+address) and show-ahead; mem_we = FIFO not empty; pop on mem_we & mem_ready.
REQ-022 With the FIFO empty and mem_ready=1, a completing odd write SHALL appear on mem_we exactly 1 cycle later.
REQ-023 A push and a pop in the same cycle SHALL both take effect when full; occupancy is unchanged.
REQ-024 A push when full without a simultaneous pop SHALL drop the word and set overflow.
REQ-025 res_done SHALL move the FSM to DRAIN. Any pending half word is pushed as {30'd0, latched} with pair_err set.
REQ-026 In DRAIN, done SHALL pulse one cycle after the FIFO empties, then the FSM returns to EMPTY.
REQ-027 res_write in DRAIN SHALL be dropped with pair_err set.
REQ-028 res_write and res_done in the same cycle SHALL process the write first, then enter DRAIN.
REQ-029 pair_err and overflow SHALL clear only on reset.

Reset
REQ-030 rst=0 SHALL asynchronously clear the FSM to EMPTY, empty the FIFO and zero every output (mem_din, mem_addr, mem_we, done, pair_err, overflow).
REQ-031 Reset mid-burst SHALL discard the latched half word and all FIFO contents; no write occurs after release until new input arrives.
REQ-032 in_ready SHALL read 1 after reset.

Configuration
REQ-033 Macro RES_COLLECT_ERRFLAG_EN defined: pair_err and overflow are built as specified.
REQ-034 Macro RES_COLLECT_ERRFLAG_EN undefined: both outputs are tied 0. Dropping and zero-padding behaviour is unchanged.

Structure
REQ-035 Shared package residue_pkg SHALL hold RES_W=30, ADDR_W=6, CNT_W=3, NUM_QI=6, FIFO_DEPTH=4 and the FSM state encoding.
REQ-036 The FIFO SHALL be the sub-module res_pack_fifo, with push, pop, full, empty and show-ahead data.

Verification
REQ-037 Writes (cnt 2, addr 4, 0x1234567) then (cnt 2, addr 5, 0x0ABCDEF), mem_ready=1 -> next cycle mem_we=1, mem_addr=0x42, mem_din={0x0ABCDEF,0x1234567}.
REQ-038 64 paired writes for cnt 0..5 with res_done last -> 192 writes, addresses in order, then done one cycle after the FIFO empties, no errors.
REQ-039 mem_ready=0 and 5 completed pairs -> in_ready=0 after 4; fifth word dropped; overflow=1; first 4 words drain intact after mem_ready=1.
REQ-040 Writes addr 6 then addr 8 (cnt 1) -> word {0,res6} at 0x23, pair_err=1, FSM in HALF holding addr 8.
REQ-041 rst low mid-pair with 2 FIFO words -> outputs 0 immediately; no mem_we after release.
REQ-042 Rebuild without RES_COLLECT_ERRFLAG_EN, rerun REQ-040 -> pair_err stays 0, same memory writes.
